// File: rtl/shf_pkg.sv
// Shared definitions for the SHF pipeline stage: operation encodings,
// condition-code width, buffer-entry layout and the CC helper.
package shf_pkg;

    // Encodings of in_ctrl[5:4]
    typedef enum logic [1:0] {
        OP_LSHF    = 2'b00,
        OP_RSHFL   = 2'b01,
        OP_ILLEGAL = 2'b10,
        OP_RSHFA   = 2'b11
    } shf_op_e;

    localparam int unsigned CC_W   = 3;
    localparam int unsigned DATA_W = 16;

    // One result-buffer slot: shifted data plus its {N,Z,P} codes
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CC_W-1:0]   cc;
    } shf_entry_t;

    // {N,Z,P}: negative wins over zero, zero over positive
    function automatic logic [CC_W-1:0] calc_cc(input logic [DATA_W-1:0] value);
        if (value[DATA_W-1])
            return 3'b100;
        else if (value == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage : shf_pkg

// File: rtl/shf_core.sv
// Combinational 16-bit shifter for the SHF instruction. Amount 0 and the
// illegal op both pass the operand through unchanged.
module shf_core
    import shf_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        amount4,
    input  shf_op_e           op,
    output logic [DATA_W-1:0] result
);

    // Select the shift flavour; arithmetic right shift replicates bit 15
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        result = data;
        case (op)
            OP_LSHF:  result = data << amount4;
            OP_RSHFL: result = data >> amount4;
            OP_RSHFA: result = DATA_W'($signed(data) >>> amount4);
            default:  result = data;
        endcase
    end

endmodule : shf_core

// File: rtl/shf_pipe_stage.sv
// SHF pipeline stage: shifts an accepted operand, stores result (and
// optionally its condition codes) in a 2-entry FIFO and presents the head.
// Optional feature macro: SHF_CC_EN -- when defined, {N,Z,P} codes are
// computed at acceptance and stored per entry; otherwise out_cc is 3'b000.
module shf_pipe_stage
    import shf_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [5:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CC_W-1:0]   out_cc,
    output logic              err_illegal
);

    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic              push, pop;
    logic [DATA_W-1:0] shf_result;
    logic [DATA_W-1:0] head_data;
    logic [CC_W-1:0]   head_cc;
    shf_op_e           in_op;

    assign in_op = shf_op_e'(in_ctrl[5:4]);

    // The result is formed at acceptance, so the buffer holds final values
    shf_core u_core (
        .data    (in_data),
        .amount4 (in_ctrl[3:0]),
        .op      (in_op),
        .result  (shf_result)
    );

    // Handshake flags come only from registered state (no out_ready -> in_ready path)
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state for occupancy, pointers and the sticky illegal-op flag
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push)
            wr_ptr_d = ~wr_ptr_q;
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        if (push && (in_op == OP_ILLEGAL))
            err_d = 1'b1;
    end

    // Control state; reset clears it immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples the pre-edge value of its neighbours.
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef SHF_CC_EN
    shf_entry_t buf_q [2];

    // Write the result and its codes into the slot at the write pointer
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; an empty buffer is never read
        // because the outputs below are forced to zero while count is 0.
        if (push)
            buf_q[wr_ptr_q] <= '{data: shf_result, cc: calc_cc(shf_result)};
    end

    assign head_data = buf_q[rd_ptr_q].data;
    assign head_cc   = buf_q[rd_ptr_q].cc;
`else
    logic [DATA_W-1:0] buf_q [2];

    // Write the result into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push)
            buf_q[wr_ptr_q] <= shf_result;
    end

    assign head_data = buf_q[rd_ptr_q];
    assign head_cc   = '0;
`endif

    // Present the head only when it holds a valid result; zero otherwise
    assign out_data    = out_valid ? head_data : '0;
    assign out_cc      = out_valid ? head_cc   : '0;
    assign err_illegal = err_q;

endmodule : shf_pipe_stage

// File: tb/tb_shf_pipe_stage.sv
// Self-checking bench for shf_pipe_stage: directed cases followed by random
// traffic, all compared against a queue-based reference model.
module tb_shf_pipe_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_cc;
    logic        err_illegal;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  cc;
    } exp_t;

    exp_t model_q[$];
    bit   err_exp;
    int   checks;
    int   failures;
    bit   accepted;

    shf_pipe_stage #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cc      (out_cc),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shifts as multiplication/division by a power of two
    function automatic exp_t ref_result(input logic [15:0] d, input logic [5:0] c);
        int unsigned p = 32'd1 << c[3:0];
        int unsigned v = 32'(d);
        int unsigned r;
        exp_t e;
        case (c[5:4])
            2'b00: r = (v * p) % 65536;
            2'b01: r = v / p;
            2'b11: begin
                r = v / p;
                if (d[15]) r = r + (65535 - 65535 / p);
            end
            default: r = v;
        endcase
        e.d = r[15:0];
`ifdef SHF_CC_EN
        if (r >= 32768)   e.cc = 3'b100;
        else if (r == 0)  e.cc = 3'b010;
        else              e.cc = 3'b001;
`else
        e.cc = 3'b000;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        chk("err_illegal", 32'(err_illegal), 32'(err_exp));
        if (model_q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(model_q[0].d));
            chk("out_cc", 32'(out_cc), 32'(model_q[0].cc));
        end
    endtask

    // Check current outputs, advance the model, then move to the next negedge
    task automatic cycle();
        bit do_push;
        bit do_pop;
        chk_state();
        do_push = in_valid && (model_q.size() < 2);
        do_pop  = out_ready && (model_q.size() > 0);
        accepted = do_push;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back(ref_result(in_data, in_ctrl));
            if (in_ctrl[5:4] == 2'b10) err_exp = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one operand until accepted, bounded by a cycle budget
    task automatic send(input logic [15:0] d, input logic [5:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) cycle();
        chk("send_accept_timeout", 32'(accepted), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8 && model_q.size() > 0; i++) cycle();
        chk("drain_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        err_exp   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_ctrl   = 6'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_cc", 32'(out_cc), 32'h0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // RSHFA by 4 of a negative value: 1-cycle latency to out_valid
        out_ready = 1'b0;
        send(16'h8000, 6'b11_0100);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("rshfa_data", 32'(out_data), 32'hF800);
        drain();

        // Directed shift corners, including amount 0 and RSHFA 15
        send(16'h0001, 6'b00_1111); drain();
        send(16'h8000, 6'b01_1111); drain();
        send(16'h0001, 6'b01_0001); drain();
        send(16'h8000, 6'b11_1111); drain();
        send(16'hA5C3, 6'b00_0000); drain();
        send(16'hA5C3, 6'b01_0000); drain();
        send(16'hA5C3, 6'b11_0000); drain();
        send(16'h7FFF, 6'b11_1111); drain();

        // Back-pressure: A and B fill the buffer, C waits, then all drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1111; in_ctrl = 6'b00_0001; cycle();
        in_data   = 16'h2222; in_ctrl = 6'b01_0001; cycle();
        in_data   = 16'h3333; in_ctrl = 6'b11_0010;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("c_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        drain();

        // Illegal op passes data through and sets the sticky flag
        out_ready = 1'b0;
        send(16'h1234, 6'b10_0011);
        chk("illegal_data", 32'(out_data), 32'h1234);
        chk("illegal_err", 32'(err_illegal), 32'd1);
        drain();
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), {1'b0, 1'($urandom), 4'($urandom)});
            drain();
        end
        chk("err_sticky", 32'(err_illegal), 32'd1);

        // Asynchronous reset with a full buffer, between clock edges
        out_ready = 1'b0;
        send(16'h0F0F, 6'b00_0100);
        send(16'hF0F0, 6'b01_0100);
        chk("prerst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_data", 32'(out_data), 32'h0);
        chk("async_err", 32'(err_illegal), 32'd0);
        model_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_empty", 32'(out_valid), 32'd0);
        send(16'h00F0, 6'b00_0100);
        chk("postrst_lat", 32'(out_valid), 32'd1);
        chk("postrst_data", 32'(out_data), 32'h0F00);
        drain();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_ctrl   = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shf_pipe_stage

// File: doc/shf_pipe_stage.md
SHF_PIPE_STAGE -- requirements
Module: shf_pipe_stage

Interface
REQ-001 Parameter BUF_DEPTH, default 2: output buffer entries; only the value 2 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  stage can accept an operand this cycle.
REQ-006 in_data  input  16  operand to shift.
REQ-007 in_ctrl  input  6  SHF instruction field: [3:0] amount4, [5:4] op (00 LSHF, 01 RSHFL, 11 RSHFA, 10 illegal).
REQ-008 out_valid  output  1  buffered result available.
REQ-009 out_ready  input  1  downstream accepts the head result.
REQ-010 out_data  output  16  shifted result at the buffer head.
REQ-011 out_cc  output  3  condition codes {N,Z,P} of out_data.
REQ-012 err_illegal  output  1  sticky flag: an illegal op was accepted.

Function
REQ-013 A transfer in occurs on a rising edge with in_valid&in_ready; a transfer out occurs with out_valid&out_ready.
REQ-014 LSHF: result = in_data << amount4, zero fill.
REQ-015 RSHFL: result = in_data >> amount4, zero fill.
REQ-016 RSHFA: result = in_data >> amount4, fill with in_data[15]; amount 15 gives 16 copies of bit 15.
REQ-017 Amount 0 returns in_data unchanged for every op.
REQ-018 Op 10: result = in_data, err_illegal set on the accepting edge and held until reset.
REQ-019 Result and CC are computed at acceptance and stored in the buffer; latency from acceptance to out_valid is exactly 1 cycle when the buffer is empty.
REQ-020 Buffer is a 2-entry FIFO with count 0..2; results leave in acceptance order.
REQ-021 in_ready = (count < 2), driven from registers only; no combinational path from out_ready to in_ready.
REQ-022 out_valid = (count > 0); out_data/out_cc present the head entry and stay stable while out_valid&!out_ready.
REQ-023 Simultaneous push and pop at count 1: count stays 1, head becomes the new entry.
REQ-024 At count 2 no push occurs; a pop reduces count to 1 and raises in_ready in the following cycle.
REQ-025 Pop at count 0 and push at count 2 are impossible by construction; the read/write pointer wraps modulo 2.

Reset
REQ-026 rst_n low immediately clears count, both pointers and err_illegal, regardless of clk.
REQ-027 During and after reset: out_valid=0, in_ready=1, out_data=16'h0000, out_cc=3'b000.
REQ-028 Reset mid-operation discards all buffered results; no partial result is presented after release.

Configuration
REQ-029 Macro SHF_CC_EN defined: out_cc = 100 if result[15], 010 if result==0, else 001, stored per entry.
REQ-030 SHF_CC_EN undefined: out_cc tied to 3'b000, no CC storage; port list unchanged.

Structure
REQ-031 Package shf_pkg holds the op encodings (LSHF, RSHFL, RSHFA, illegal), the CC width, and the buffer-entry struct {data[15:0], cc[2:0]}.
REQ-032 Sub-module shf_core: combinational 16-bit shifter, inputs data, amount4 and op, output result; the stage instantiates it once at the input.

Verification
REQ-033 in_data=16'h8000, in_ctrl=6'b11_0100 accepted with the buffer empty -> next cycle out_valid=1, out_data=16'hF800, out_cc=100.
REQ-034 16'h0001 LSHF 15 -> 16'h8000, cc 100; 16'h8000 RSHFL 15 -> 16'h0001, cc 001; 16'h0001 RSHFL 1 -> 16'h0000, cc 010.
REQ-035 out_ready=0 with three back-to-back in_valid operands A, B, C -> A and B accepted, in_ready=0 from the cycle after B; out_ready=1 -> A, B, C drain in order with no loss or duplication.
REQ-036 Operand with in_ctrl=6'b10_0011 and in_data=16'h1234 -> out_data=16'h1234, err_illegal=1, still 1 after 10 further legal operations.
REQ-037 rst_n driven low between clock edges with count=2 -> out_valid=0 and in_ready=1 without waiting for a clock edge; after release the first new operand appears with 1-cycle latency.
REQ-038 Build without SHF_CC_EN, repeat REQ-033 -> out_data=16'hF800, out_cc=000.
